// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and the arbitration rule for the CPU/DMA memory port arbiter.
// Keeping the rule here lets the FSM and anything else that needs it agree on one definition.
package mem_port_arbiter_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // CPU has fixed priority unless the DMA port has been passed over MAX_WAIT times.
    function automatic logic dma_wins(input logic cpu_req, input logic dma_req, input logic starved);
        return dma_req & (~cpu_req | starved);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of CPU grants made while the DMA port was waiting.
// Clear has priority over increment.
module arb_starve_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic             sat,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sat = (cnt_q == CNT_W'(MAX_WAIT));
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the multicycle CPU and a DMA/loader port.
// IDLE arbitrates and latches the winner's request, ACCESS runs MEM_LAT cycles, RESP acks for one cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state,
    output logic [CNT_W-1:0]  dbg_wait_cnt
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    logic in_idle;
    logic in_access;
    logic last_beat;
    logic starved;
    logic grant_dma;
    logic any_req;

    assign in_idle   = (state_q == IDLE);
    assign in_access = (state_q == ACCESS);
    assign last_beat = in_access && (lat_q == LAT_LAST);
    assign any_req   = cpu_req | dma_req;
    assign grant_dma = dma_wins(cpu_req, dma_req, starved);

    // The count only moves on IDLE decisions; a DMA port that drops its request forfeits its credit.
    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (in_idle & cpu_req & dma_req & ~grant_dma),
        .clr   (~dma_req | (in_idle & grant_dma)),
        .sat   (starved),
        .cnt   (dbg_wait_cnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    owner_d = grant_dma ? OWN_DMA : OWN_CPU;
                    we_d    = grant_dma ? dma_we : cpu_we;
                    addr_d  = grant_dma ? dma_addr : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                    lat_d   = '0;
                end
            end
            ACCESS: begin
                if (last_beat) begin
                    state_d = RESP;
                    if (!we_q && owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    if (!we_q && owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lat_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign mem_read  = in_access & ~we_q;
    assign mem_write = in_access & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
    assign dma_ack   = (state_q == RESP) && (owner_q == OWN_DMA);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3) share stimulus; sel picks the one observed.
// Vector table, hand sequences for reset/starvation/address hold, then random traffic against a memory model.
module tb_mem_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] mem_rdata;
    logic        sel;

    logic [31:0] cpu_rdata_v [0:1];
    logic [31:0] dma_rdata_v [0:1];
    logic [31:0] mem_addr_v  [0:1];
    logic [31:0] mem_wdata_v [0:1];
    logic        cpu_ack_v   [0:1];
    logic        cpu_stall_v [0:1];
    logic        dma_ack_v   [0:1];
    logic        mem_read_v  [0:1];
    logic        mem_write_v [0:1];
    logic [1:0]  state_v     [0:1];
    logic [2:0]  wcnt_v      [0:1];

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W (32), .DATA_W (32), .MEM_LAT ((g == 0) ? 1 : 3), .MAX_WAIT (MAX_WAIT)
        ) u_dut (
            .clk (clk), .reset (reset),
            .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
            .cpu_rdata (cpu_rdata_v[g]), .cpu_ack (cpu_ack_v[g]), .cpu_stall (cpu_stall_v[g]),
            .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr), .dma_wdata (dma_wdata),
            .dma_rdata (dma_rdata_v[g]), .dma_ack (dma_ack_v[g]),
            .mem_read (mem_read_v[g]), .mem_write (mem_write_v[g]),
            .mem_addr (mem_addr_v[g]), .mem_wdata (mem_wdata_v[g]), .mem_rdata (mem_rdata),
            .dbg_state (state_v[g]), .dbg_wait_cnt (wcnt_v[g])
        );
    end

    wire [31:0] cpu_rdata = cpu_rdata_v[sel];
    wire [31:0] dma_rdata = dma_rdata_v[sel];
    wire [31:0] mem_addr  = mem_addr_v[sel];
    wire [31:0] mem_wdata = mem_wdata_v[sel];
    wire        cpu_ack   = cpu_ack_v[sel];
    wire        cpu_stall = cpu_stall_v[sel];
    wire        dma_ack   = dma_ack_v[sel];
    wire        mem_read  = mem_read_v[sel];
    wire        mem_write = mem_write_v[sel];
    wire [1:0]  dbg_state = state_v[sel];
    wire [2:0]  wait_cnt  = wcnt_v[sel];

    // memory: either a fixed read word (vectors) or a 16-word array (random traffic)
    logic        use_model;
    logic [31:0] fixed_rdata;
    logic [31:0] mem_arr   [0:15];
    logic [31:0] model_mem [0:15];
    assign mem_rdata = use_model ? mem_arr[mem_addr[5:2]] : fixed_rdata;

    always @(posedge clk) begin
        if (use_model && mem_write) mem_arr[mem_addr[5:2]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Wait for the next ack, counting cycles and checking every strobe cycle against the expected access.
    task automatic run_txn(input bit exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                           output int n, output int strb, output int bad, output bit got_dma);
        n = 0; strb = 0; bad = 0; got_dma = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (mem_read || mem_write) begin
                strb++;
                if (mem_write != exp_we || mem_read == exp_we || mem_addr != exp_addr ||
                    (exp_we && mem_wdata != exp_wd)) bad++;
            end
            if (cpu_ack || dma_ack) begin
                got_dma = dma_ack;
                chk("single_ack", {63'd0, cpu_ack & dma_ack}, 64'd0);
                return;
            end
        end
        n = 999;
    endtask

    typedef struct {
        bit          lat3;
        bit          cpu_r;
        bit          cpu_w;
        bit          dma_r;
        bit          dma_w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdval;
        bit          exp_dma;
        int          exp_n;
        logic [31:0] exp_rdata;
        int          exp_n2;
        logic [31:0] exp_rdata2;
    } vec_t;

    vec_t vecs [7];

    logic [31:0] last_cpu, last_dma;
    int          cpu_ack_total;
    bit          cpu_done, dma_done;

    task automatic cpu_drv(input int count);
        for (int i = 0; i < count; i++) begin
            int          idx, k;
            bit          we;
            logic [31:0] wd;
            repeat ($urandom_range(0, 3)) tick();
            idx = $urandom_range(0, 15);
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            cpu_we = we; cpu_addr = 32'(idx) << 2; cpu_wdata = wd; cpu_req = 1'b1;
            k = 0;
            do begin tick(); k++; end while (!cpu_ack && k < 200);
            chk("rnd_cpu_ack_seen", {63'd0, cpu_ack}, 64'd1);
            if (cpu_ack) begin
                if (!we) begin
                    chk("rnd_cpu_rdata", {32'd0, cpu_rdata}, {32'd0, model_mem[idx]});
                    last_cpu = model_mem[idx];
                end else begin
                    chk("rnd_cpu_wr_keep", {32'd0, cpu_rdata}, {32'd0, last_cpu});
                    model_mem[idx] = wd;
                end
                cpu_ack_total++;
            end
            cpu_req = 1'b0;
        end
    endtask

    task automatic dma_drv(input int count);
        for (int i = 0; i < count; i++) begin
            int          idx, k, start;
            bit          we;
            logic [31:0] wd;
            repeat ($urandom_range(0, 3)) tick();
            idx = $urandom_range(0, 15);
            we  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            dma_we = we; dma_addr = 32'(idx) << 2; dma_wdata = wd; dma_req = 1'b1;
            start = cpu_ack_total;
            k = 0;
            do begin tick(); k++; end while (!dma_ack && k < 200);
            chk("rnd_dma_ack_seen", {63'd0, dma_ack}, 64'd1);
            if (dma_ack) begin
                // one CPU access may already be in flight, then at most MAX_WAIT more grants
                chk("rnd_dma_wait_bound", {63'd0, (cpu_ack_total - start) <= MAX_WAIT + 1}, 64'd1);
                if (!we) begin
                    chk("rnd_dma_rdata", {32'd0, dma_rdata}, {32'd0, model_mem[idx]});
                    last_dma = model_mem[idx];
                end else begin
                    chk("rnd_dma_wr_keep", {32'd0, dma_rdata}, {32'd0, last_dma});
                    model_mem[idx] = wd;
                end
            end
            dma_req = 1'b0;
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, strb, bad, lat, cnt_a, max_w;
        bit          got_dma, seen;
        logic [31:0] dma_a;

        sel = 0; use_model = 0; fixed_rdata = '0; reset = 1'b1;
        idle_inputs();

        vecs[0] = '{0, 1, 0, 0, 0, 32'h10, 32'h0,    32'hDEADBEEF, 0, 2, 32'hDEADBEEF, 0, 32'h0};
        vecs[1] = '{1, 0, 0, 1, 1, 32'h20, 32'h55,   32'h99999999, 1, 4, 32'h0,        0, 32'h0};
        vecs[2] = '{0, 1, 0, 1, 0, 32'h40, 32'h0,    32'hCAFEF00D, 0, 2, 32'hCAFEF00D, 3, 32'hCAFEF00D};
        vecs[3] = '{1, 1, 1, 0, 0, 32'h44, 32'h1234, 32'h87654321, 0, 4, 32'h0,        0, 32'h0};
        vecs[4] = '{1, 0, 0, 1, 0, 32'h80, 32'h0,    32'h0000A5A5, 1, 4, 32'h0000A5A5, 0, 32'h0};
        vecs[5] = '{1, 1, 1, 1, 0, 32'h48, 32'h77,   32'h31415926, 0, 4, 32'h0,        5, 32'h31415926};
        vecs[6] = '{0, 0, 0, 1, 0, 32'h0C, 32'h0,    32'h0BADF00D, 1, 2, 32'h0BADF00D, 0, 32'h0};

        // reset state
        do_reset();
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        chk("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
        chk("rst_acks", {62'd0, cpu_ack, dma_ack}, 64'd0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 64'd0);
        chk("rst_wait_cnt", {61'd0, wait_cnt}, 64'd0);

        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].lat3;
            lat = vecs[v].lat3 ? 3 : 1;
            do_reset();
            fixed_rdata = vecs[v].rdval;
            dma_a = vecs[v].addr ^ 32'h100;
            cpu_req = vecs[v].cpu_r; cpu_we = vecs[v].cpu_w;
            cpu_addr = vecs[v].addr; cpu_wdata = vecs[v].wdata;
            dma_req = vecs[v].dma_r; dma_we = vecs[v].dma_w;
            dma_addr = dma_a; dma_wdata = vecs[v].wdata ^ 32'hFF;
            if (vecs[v].exp_dma) run_txn(vecs[v].dma_w, dma_a, vecs[v].wdata ^ 32'hFF, n, strb, bad, got_dma);
            else                 run_txn(vecs[v].cpu_w, vecs[v].addr, vecs[v].wdata, n, strb, bad, got_dma);
            chk($sformatf("vec%0d_owner", v), {63'd0, got_dma}, {63'd0, vecs[v].exp_dma});
            chk($sformatf("vec%0d_latency", v), 64'(n), 64'(vecs[v].exp_n));
            chk($sformatf("vec%0d_strobe_cycles", v), 64'(strb), 64'(lat));
            chk($sformatf("vec%0d_strobe_bad", v), 64'(bad), 64'd0);
            if (vecs[v].exp_dma) begin
                chk($sformatf("vec%0d_rdata", v), {32'd0, dma_rdata}, {32'd0, vecs[v].exp_rdata});
                chk($sformatf("vec%0d_other_rdata", v), {32'd0, cpu_rdata}, 64'd0);
                dma_req = 1'b0;
            end else begin
                chk($sformatf("vec%0d_rdata", v), {32'd0, cpu_rdata}, {32'd0, vecs[v].exp_rdata});
                chk($sformatf("vec%0d_other_rdata", v), {32'd0, dma_rdata}, 64'd0);
                cpu_req = 1'b0;
            end
            if (vecs[v].exp_n2 != 0) begin
                run_txn(vecs[v].dma_w, dma_a, vecs[v].wdata ^ 32'hFF, n, strb, bad, got_dma);
                chk($sformatf("vec%0d_second_owner", v), {63'd0, got_dma}, 64'd1);
                chk($sformatf("vec%0d_second_latency", v), 64'(n), 64'(vecs[v].exp_n2));
                chk($sformatf("vec%0d_second_bad", v), 64'(bad), 64'd0);
                chk($sformatf("vec%0d_second_rdata", v), {32'd0, dma_rdata}, {32'd0, vecs[v].exp_rdata2});
                dma_req = 1'b0;
            end
            tick();
        end

        // reset asserted for two cycles in the middle of an ACCESS
        sel = 1;
        do_reset();
        fixed_rdata = 32'h11111111;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        tick();
        tick();
        chk("midrst_in_access", {62'd0, dbg_state}, 64'd1);
        reset = 1'b0;
        tick();
        chk("midrst_strobe_off", {62'd0, mem_read, mem_write}, 64'd0);
        chk("midrst_state_idle", {62'd0, dbg_state}, 64'd0);
        chk("midrst_no_ack1", {62'd0, cpu_ack, dma_ack}, 64'd0);
        tick();
        chk("midrst_no_ack2", {62'd0, cpu_ack, dma_ack}, 64'd0);
        cpu_req = 0;
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (cpu_ack || dma_ack) seen = 1;
        end
        chk("midrst_no_late_ack", {63'd0, seen}, 64'd0);
        chk("midrst_rdata", {32'd0, cpu_rdata}, 64'd0);

        // CPU holds its request continuously while DMA waits
        sel = 0;
        do_reset();
        fixed_rdata = 32'h0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
        dma_req = 1; dma_we = 0; dma_addr = 32'h8;
        cnt_a = 0; max_w = 0; seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (int'(wait_cnt) > max_w) max_w = int'(wait_cnt);
            if (cpu_ack) cnt_a++;
            if (dma_ack) begin
                seen = 1;
                chk("starve_wait_cleared", {61'd0, wait_cnt}, 64'd0);
                break;
            end
        end
        chk("starve_dma_acked", {63'd0, seen}, 64'd1);
        chk("starve_cpu_acks", 64'(cnt_a), 64'(MAX_WAIT));
        chk("starve_wait_max", 64'(max_w), 64'(MAX_WAIT));
        dma_req = 0;
        run_txn(1'b0, 32'h4, 32'h0, n, strb, bad, got_dma);
        chk("starve_cpu_after", {63'd0, got_dma}, 64'd0);
        chk("starve_cpu_after_latency", 64'(n), 64'd3);
        cpu_req = 0;
        tick();

        // request fields are frozen at grant; stall holds until ack
        sel = 1;
        do_reset();
        fixed_rdata = 32'h00000777;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        n = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (n == 1) cpu_addr = 32'h14;
            if (mem_read) chk("hold_mem_addr", {32'd0, mem_addr}, 64'h10);
            if (cpu_ack) begin
                seen = 1;
                chk("hold_stall_at_ack", {63'd0, cpu_stall}, 64'd0);
                break;
            end
            chk("hold_stall", {63'd0, cpu_stall}, 64'd1);
        end
        chk("hold_acked", {63'd0, seen}, 64'd1);
        chk("hold_rdata", {32'd0, cpu_rdata}, 64'h777);
        cpu_req = 0;
        tick();

        // random traffic from both ports against the memory model
        for (int s = 0; s < 2; s++) begin
            int mis;
            sel = 1'(s);
            do_reset();
            use_model = 1;
            for (int i = 0; i < 16; i++) begin
                mem_arr[i]   = $urandom;
                model_mem[i] = mem_arr[i];
            end
            last_cpu = '0; last_dma = '0; cpu_ack_total = 0;
            cpu_done = 0; dma_done = 0;
            cnt_a = 0;
            fork
                begin cpu_drv(40); cpu_done = 1; end
                begin dma_drv(30); dma_done = 1; end
                begin
                    for (int t = 0; t < 20000 && !(cpu_done && dma_done); t++) begin
                        tick();
                        if (cpu_ack && dma_ack) cnt_a++;
                    end
                end
            join
            chk("rnd_dual_acks", 64'(cnt_a), 64'd0);
            mis = 0;
            for (int i = 0; i < 16; i++) if (mem_arr[i] !== model_mem[i]) mis++;
            chk("rnd_mem_contents", 64'(mis), 64'd0);
            use_model = 0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
